// File: rtl/frame_mux2_switch_pkg.sv
// Shared definitions for the two-source serial frame switch: state codes
// and default frame/guard geometry.
package frame_mux2_switch_pkg;

  // Two-bit state codes kept as plain constants for legacy tools.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [1:0] ST_SYNC  = 2'd3;

  localparam int FRAME_BITS_DEF   = 8;
  localparam int GUARD_CYCLES_DEF = 16;

  // Guard down-counter preset: the counter runs preset..0, so a preset of
  // cycles-1 gives exactly `cycles` clocks spent in GUARD.
  function automatic logic [15:0] guard_load(input int cycles);
    return 16'(cycles - 1);
  endfunction

endpackage

// File: rtl/frame_mux2_switch.sv
// Two-source serial frame switch. Forwards the bit stream of the source that
// currently owns the output, lets an in-flight frame finish before handing
// over, inserts a fixed idle guard, then waits for a frame start on the new
// source before forwarding again.
module frame_mux2_switch
  import frame_mux2_switch_pkg::*;
#(
  parameter int FRAME_BITS   = FRAME_BITS_DEF,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_en,
  input  logic sel,
  input  logic y0,
  input  logic y1,
  input  logic frm0,
  input  logic frm1,
  output logic x,
  output logic x_frm,
  output logic cur_src,
  output logic busy
);

  localparam logic [7:0]  FB         = 8'(FRAME_BITS);
  localparam logic [15:0] GUARD_INIT = guard_load(GUARD_CYCLES);

  logic [1:0]  state;
  logic [7:0]  bcnt;
  logic        in_frame;
  logic [15:0] gcnt;

  logic [1:0]  state_n;
  logic [15:0] gcnt_n;
  logic        src_n;
  logic        fwd;
  logic        clr;
  logic        frm_c;
  logic        y_c;
  logic [7:0]  bcnt_inc;
  logic        frame_done;

  // Next-state, guard count and forwarding decision for this clock.
  always_comb begin
    frm_c      = cur_src ? frm1 : frm0;
    y_c        = cur_src ? y1 : y0;
    bcnt_inc   = bcnt + 8'd1;
    frame_done = bit_en && !frm_c && in_frame && (bcnt_inc == FB);
    state_n    = state;
    gcnt_n     = gcnt;
    src_n      = cur_src;
    fwd        = 1'b0;
    clr        = 1'b0;
    case (state)
      ST_RUN: begin
        fwd = bit_en;
        if (sel != cur_src) begin
          if (in_frame) begin
            state_n = ST_DRAIN;
          end else begin
            state_n = ST_GUARD;
            gcnt_n  = GUARD_INIT;
          end
        end
      end
      ST_DRAIN: begin
        fwd = bit_en;
        if (sel == cur_src) begin
          state_n = ST_RUN;
        end else if (frame_done) begin
          state_n = ST_GUARD;
          gcnt_n  = GUARD_INIT;
        end
      end
      ST_GUARD: begin
        // sel is only looked at on the final guard clock, so toggling it
        // earlier cannot stretch or restart the guard.
        if (gcnt == 16'd0) begin
          state_n = ST_SYNC;
          src_n   = sel;
          clr     = 1'b1;
        end else begin
          gcnt_n = gcnt - 16'd1;
        end
      end
      default: begin
        if (sel != cur_src) begin
          state_n = ST_GUARD;
          gcnt_n  = GUARD_INIT;
        end else if (bit_en && frm_c) begin
          // The frame-start slot that ends SYNC is itself forwarded.
          state_n = ST_RUN;
          fwd     = 1'b1;
        end
      end
    endcase
  end

  // Control registers, frame bit counter and registered serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_SYNC;
      cur_src  <= 1'b0;
      x        <= 1'b0;
      x_frm    <= 1'b0;
      bcnt     <= 8'd0;
      in_frame <= 1'b0;
      gcnt     <= 16'd0;
      busy     <= 1'b1;
    end else begin
      state   <= state_n;
      gcnt    <= gcnt_n;
      cur_src <= src_n;
      busy    <= (state_n != ST_RUN);

      // A frame start always re-anchors the count, even mid-frame.
      if (clr) begin
        bcnt     <= 8'd0;
        in_frame <= 1'b0;
      end else if (bit_en) begin
        if (frm_c) begin
          bcnt     <= 8'd1;
          in_frame <= 1'b1;
        end else if (in_frame) begin
          bcnt <= bcnt_inc;
          if (bcnt_inc == FB) begin
            in_frame <= 1'b0;
          end
        end
      end

      if (fwd) begin
        x     <= y_c;
        x_frm <= frm_c;
      end else if (state == ST_GUARD || state == ST_SYNC) begin
        x     <= 1'b0;
        x_frm <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_mux2_switch.sv
// Directed bench for frame_mux2_switch: each step queues the outputs expected
// after the next clock edge, drives the inputs, then pops and compares.
module tb_frame_mux2_switch;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit_en = 1'b0;
  logic sel = 1'b0;
  logic y0 = 1'b0;
  logic y1 = 1'b0;
  logic frm0 = 1'b0;
  logic frm1 = 1'b0;
  logic x, x_frm, cur_src, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    logic  ex;
    logic  exf;
    logic  eb;
    logic  es;
  } exp_t;

  exp_t exp_q[$];

  frame_mux2_switch #(.FRAME_BITS(8), .GUARD_CYCLES(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .bit_en (bit_en),
    .sel    (sel),
    .y0     (y0),
    .y1     (y1),
    .frm0   (frm0),
    .frm1   (frm1),
    .x      (x),
    .x_frm  (x_frm),
    .cur_src(cur_src),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one clock of inputs; expected outputs apply right after the edge.
  task automatic step(input logic be, input logic s, input logic a0, input logic a1,
                      input logic f0, input logic f1,
                      input logic ex, input logic exf, input logic eb, input logic es,
                      input string tag);
    exp_t e;
    exp_q.push_back('{tag, ex, exf, eb, es});
    bit_en = be; sel = s; y0 = a0; y1 = a1; frm0 = f0; frm1 = f1;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, ".x"},     {7'd0, x},       {7'd0, e.ex});
    chk({e.tag, ".x_frm"}, {7'd0, x_frm},   {7'd0, e.exf});
    chk({e.tag, ".busy"},  {7'd0, busy},    {7'd0, e.eb});
    chk({e.tag, ".src"},   {7'd0, cur_src}, {7'd0, e.es});
  endtask

  initial begin
    logic [7:0] pat;
    logic b;
    logic s;

    // Reset state
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "rst0");
    step(1, 0, 1, 1, 1, 1, 0, 0, 1, 0, "rst1");
    chk("rst.bcnt", dut.bcnt, 8'd0);
    chk("rst.in_frame", {7'd0, dut.in_frame}, 8'd0);
    reset = 1'b0;

    // Basic frame on source 0, with one idle gap to check hold
    step(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, "a_sync_idle");
    pat = 8'b10110010;
    for (int i = 0; i < 8; i++) begin
      b = pat[7-i];
      step(1, 0, b, ~b, (i == 0), 0, b, (i == 0), 0, 0, $sformatf("a_bit%0d", i));
      if (i == 2) step(0, 0, ~b, b, 0, 0, b, 0, 0, 0, "a_hold");
    end

    // Resync: second frm0 on bit index 3 reloads the counter
    for (int i = 0; i < 11; i++) begin
      b = i[0];
      step(1, 0, b, ~b, (i == 0 || i == 3), 0, b, (i == 0 || i == 3), 0, 0,
           $sformatf("b_bit%0d", i));
      chk($sformatf("b_bcnt%0d", i), dut.bcnt, (i < 3) ? 8'(i + 1) : 8'(i - 2));
      chk($sformatf("b_inf%0d", i), {7'd0, dut.in_frame}, (i == 10) ? 8'd0 : 8'd1);
    end

    // sel 0->1 at bit 3, back to 0 at bit 5: no guard, output unbroken
    pat = 8'b11010011;
    for (int i = 0; i < 8; i++) begin
      b = pat[7-i];
      s = (i == 2 || i == 3);
      step(1, s, b, ~b, (i == 0), 0, b, (i == 0), s, 0, $sformatf("c_bit%0d", i));
    end

    // sel 0->1 at bit 3 and stays: drain rest of frame
    pat = 8'b01101110;
    for (int i = 0; i < 8; i++) begin
      b = pat[7-i];
      step(1, (i >= 2), b, ~b, (i == 0), 0, b, (i == 0), (i >= 2), 0,
           $sformatf("d_bit%0d", i));
    end
    // Guard of exactly 16 clocks, sel toggling 1->0->1 inside it
    for (int g = 1; g <= 16; g++) begin
      s = !(g == 5 || g == 6);
      step(1, s, 1, 1, (g == 3), (g == 8), 0, 0, 1, (g == 16), $sformatf("d_guard%0d", g));
    end
    // SYNC ignores data and the other source's frame flag
    step(1, 1, 1, 1, 1, 0, 0, 0, 1, 1, "d_sync_idle");
    pat = 8'b11001101;
    for (int i = 0; i < 8; i++) begin
      b = pat[7-i];
      step(1, 1, ~b, b, 0, (i == 0), b, (i == 0), 0, 1, $sformatf("d_s1bit%0d", i));
    end

    // Reset asserted at bit 5 of a forwarded source-1 frame
    pat = 8'b10101111;
    for (int i = 0; i < 4; i++) begin
      b = pat[7-i];
      step(1, 1, ~b, b, 0, (i == 0), b, (i == 0), 0, 1, $sformatf("e_bit%0d", i));
    end
    reset = 1'b1;
    step(1, 0, 1, 1, 0, 0, 0, 0, 1, 0, "e_rst");
    chk("e_rst.bcnt", dut.bcnt, 8'd0);
    reset = 1'b0;
    for (int i = 5; i < 8; i++) begin
      step(1, 0, 1, 1, 0, 0, 0, 0, 1, 0, $sformatf("e_after%0d", i));
    end
    step(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, "e_new_frm0");
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, "e_new_b1");

    // Reset released with sel=1: guard before serving source 1
    reset = 1'b1;
    step(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, "f_rst");
    reset = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step(1, 1, 1, 1, 0, 0, 0, 0, 1, (i == 17), $sformatf("f_guard%0d", i));
    end
    pat = 8'b10011110;
    for (int i = 0; i < 8; i++) begin
      b = pat[7-i];
      step(1, 1, ~b, b, 0, (i == 0), b, (i == 0), 0, 1, $sformatf("f_bit%0d", i));
    end

    // Idle switch request with no frame in flight goes straight to guard
    step(1, 0, 0, 1, 0, 0, 1, 0, 1, 1, "g_req");
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 1, 0, 0, 0, 0, 1, (i != 16), $sformatf("g_guard%0d", i));
    end
    step(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, "g_sync");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_mux2_switch.md
FRAME_MUX2_SWITCH -- requirements
Module: frame_mux2_switch

Interface
REQ-001 Parameter FRAME_BITS, default 8: number of bit slots per frame (range 2..255).
REQ-002 Parameter GUARD_CYCLES, default 16: clk cycles of forced-idle output between sources (range 1..65535).
REQ-003 Port clk  input  1  single clock for all state.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port bit_en  input  1  bit-slot strobe shared by both sources; data and frame flags are sampled only when it is high.
REQ-006 Port sel  input  1  requested source: 0 selects y0/frm0, 1 selects y1/frm1.
REQ-007 Port y0, y1  input  1 each  serial data bits of source 0 and source 1.
REQ-008 Port frm0, frm1  input  1 each  frame-start flags; high on the bit_en slot carrying bit 0 of a frame.
REQ-009 Port x  output  1  merged serial data, registered.
REQ-010 Port x_frm  output  1  merged frame-start flag, registered.
REQ-011 Port cur_src  output  1  source currently owning the output.
REQ-012 Port busy  output  1  high in any state other than RUN.

Function
REQ-013 States are RUN, DRAIN, GUARD and SYNC, encoded in 2 bits.
REQ-014 A bit counter bcnt (8 bits) loads 1 on a bit_en slot where frm of cur_src is high.
REQ-015 Otherwise bcnt increments on each bit_en slot while in_frame is high.
REQ-016 in_frame sets on frm of cur_src and clears on the bit_en slot in which bcnt reaches FRAME_BITS.
REQ-017 A frm of cur_src arriving while in_frame is high reloads bcnt to 1 (resynchronisation), with no error indication.
REQ-018 In RUN, on each bit_en slot: x <= y[cur_src] and x_frm <= frm[cur_src]. Latency is 1 clk from the bit_en slot.
REQ-019 In RUN, x and x_frm hold their values on clocks where bit_en is low.
REQ-020 RUN to DRAIN: sel != cur_src while in_frame is high.
REQ-021 RUN to GUARD: sel != cur_src while in_frame is low.
REQ-022 DRAIN forwards exactly as RUN.
REQ-023 DRAIN to GUARD: the bit_en slot that clears in_frame (frame complete).
REQ-024 DRAIN to RUN: sel returns to cur_src before the frame completes. There is no gap in x, and GUARD is not entered.
REQ-025 In GUARD and SYNC, x = 0 and x_frm = 0.
REQ-026 GUARD counts exactly GUARD_CYCLES clk cycles, independent of bit_en, using a 16-bit down-counter.
REQ-027 sel changes during GUARD neither restart nor extend the guard.
REQ-028 At the last GUARD cycle, cur_src <= sel sampled in that cycle, bcnt <= 0 and in_frame <= 0, then the block enters SYNC.
REQ-029 SYNC to RUN: the first bit_en slot with frm of cur_src high; that slot is forwarded (x_frm = 1 one clk later).
REQ-030 In SYNC, sel != cur_src moves the block to GUARD with a full new guard count.
REQ-031 If bit_en and a transition condition occur in the same clk, the forwarding rule of the state at that clk's start applies.
REQ-032 busy = 1 in DRAIN, GUARD and SYNC; busy = 0 in RUN. busy is registered and aligned with the state register.

Reset
REQ-033 While reset is high at a clk edge: state = SYNC, cur_src = 0, x = 0, x_frm = 0, bcnt = 0, in_frame = 0, guard counter = 0, busy = 1.
REQ-034 Reset mid-frame or mid-guard aborts the operation immediately; no partial frame is completed after reset.
REQ-035 After reset deasserts, with sel = 1, the block passes through GUARD (REQ-030) before serving source 1.

Structure
REQ-036 State encoding and the default FRAME_BITS and GUARD_CYCLES constants live in the shared FPGA definitions package.
REQ-037 The design is a single module with no sub-module; the bit counter and guard counter are inline.

Verification
REQ-038 Reset, sel=0, frm0 pulse with y0 = 10110010 on 8 bit_en slots -> busy 1 then 0 on the frm slot; x reproduces 10110010 at 1 clk latency; x_frm = 1 for exactly one slot.
REQ-039 sel 0->1 at bit 3 of a source-0 frame -> bits 3..7 still forwarded; then x = 0 for 16 clk; then x stays 0 until frm1; then source-1 frame forwarded; cur_src = 1.
REQ-040 sel 0->1 at bit 3, then back to 0 at bit 5 -> no GUARD entry; busy high from the change until the return; x unbroken; cur_src stays 0.
REQ-041 sel toggles 1->0->1 during GUARD -> guard length stays exactly 16 clk; cur_src = 1 at guard end.
REQ-042 Second frm0 at bit 4 of a frame -> bcnt reloads 1; in_frame clears 8 slots after the second frm0.
REQ-043 Reset asserted at bit 5 of a forwarded frame -> next clk x = 0, x_frm = 0, busy = 1; forwarding resumes only after a new frm0.
